// File: rtl/rsa_op_scheduler.sv
// rsa_op_scheduler: runs RSA key generation (public-key generator, then
// private-key generator), latches e, d and n, and shares one mod-exp engine
// between an encrypt and a decrypt requester with round-robin arbitration.
//
// Optional watchdog: define RSA_SCHED_TIMEOUT_EN to bound every *_WAIT state
// by TIMEOUT_CYCLES. Without it, waits are unbounded and err_timeout is 0.
//
// state          | meaning
// ---------------+------------------------------------------------------
// IDLE           | no valid keys, waiting for keygen_req
// READY          | keys valid, arbitrating enc/dec requests
// KG_PUB_START   | pub_start pulse
// KG_PUB_SETTLE  | pub_finish ignored (may still be high from last run)
// KG_PUB_WAIT    | waiting for pub_finish, then latch e
// KG_PRIV_START  | priv_start and pub_start pulse
// KG_PRIV_SETTLE | priv_fin ignored (may still be high from last run)
// KG_PRIV_WAIT   | waiting for priv_fin, then latch d and n
// OP_START       | eng_start and grant pulse
// OP_SETTLE      | eng_finished ignored (may still be high from last op)
// OP_WAIT        | waiting for eng_finished, then capture result
// RSP            | rsp_valid held until rsp_ready
module rsa_op_scheduler #(
    parameter int TIMEOUT_CYCLES = 4095
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        keygen_req,
    output logic        pub_start,
    input  logic        pub_finish,
    output logic        priv_start,
    input  logic        priv_fin,
    input  logic [7:0]  public_key,
    input  logic [15:0] private_key,
    input  logic [15:0] n,
    output logic        keys_valid,
    input  logic        enc_req,
    input  logic        dec_req,
    input  logic [15:0] enc_data,
    input  logic [15:0] dec_data,
    output logic        enc_gnt,
    output logic        dec_gnt,
    output logic        eng_start,
    output logic [15:0] eng_msg,
    output logic [15:0] eng_exp,
    output logic [15:0] eng_mod,
    input  logic        eng_finished,
    input  logic [15:0] eng_result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic        rsp_id,
    output logic        busy,
    output logic        err_timeout
);

    typedef enum logic [3:0] {
        IDLE,
        READY,
        KG_PUB_START,
        KG_PUB_SETTLE,
        KG_PUB_WAIT,
        KG_PRIV_START,
        KG_PRIV_SETTLE,
        KG_PRIV_WAIT,
        OP_START,
        OP_SETTLE,
        OP_WAIT,
        RSP
    } state_t;

    state_t      state, state_next;
    logic        kg_launch;
    logic        do_grant;
    logic        pick_dec;
    logic        wait_expired;
    logic        rr_dec;
    logic [7:0]  e_key;
    logic [15:0] d_key;
    logic [15:0] n_key;

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // next-state decode, arbitration and keygen launch
    always_comb begin
        state_next = state;
        kg_launch  = 1'b0;
        do_grant   = 1'b0;
        pick_dec   = 1'b0;
        case (state)
            IDLE: begin
                if (keygen_req) begin
                    state_next = KG_PUB_START;
                    kg_launch  = 1'b1;
                end
            end
            READY: begin
                if (keygen_req) begin
                    state_next = KG_PUB_START;
                    kg_launch  = 1'b1;
                end else if (enc_req || dec_req) begin
                    state_next = OP_START;
                    do_grant   = 1'b1;
                    pick_dec   = dec_req && (!enc_req || rr_dec);
                end
            end
            KG_PUB_START:   state_next = KG_PUB_SETTLE;
            KG_PUB_SETTLE:  state_next = KG_PUB_WAIT;
            KG_PUB_WAIT: begin
                if (pub_finish) begin
                    state_next = KG_PRIV_START;
                end else if (wait_expired) begin
                    state_next = IDLE;
                end
            end
            KG_PRIV_START:  state_next = KG_PRIV_SETTLE;
            KG_PRIV_SETTLE: state_next = KG_PRIV_WAIT;
            KG_PRIV_WAIT: begin
                if (priv_fin) begin
                    state_next = READY;
                end else if (wait_expired) begin
                    state_next = IDLE;
                end
            end
            OP_START:       state_next = OP_SETTLE;
            OP_SETTLE:      state_next = OP_WAIT;
            OP_WAIT: begin
                if (eng_finished || wait_expired) begin
                    state_next = RSP;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    state_next = READY;
                end
            end
            default:        state_next = IDLE;
        endcase
    end

    // registered strobes and status, decoded from the state being entered
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pub_start  <= 1'b0;
            priv_start <= 1'b0;
            eng_start  <= 1'b0;
            enc_gnt    <= 1'b0;
            dec_gnt    <= 1'b0;
            rsp_valid  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            pub_start  <= (state_next == KG_PUB_START) || (state_next == KG_PRIV_START);
            priv_start <= (state_next == KG_PRIV_START);
            eng_start  <= (state_next == OP_START);
            enc_gnt    <= do_grant && !pick_dec;
            dec_gnt    <= do_grant && pick_dec;
            rsp_valid  <= (state_next == RSP);
            busy       <= (state_next != IDLE) && (state_next != READY);
        end
    end

    // key latches, engine operands, round-robin pointer and response capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            keys_valid <= 1'b0;
            e_key      <= '0;
            d_key      <= '0;
            n_key      <= '0;
            eng_msg    <= '0;
            eng_exp    <= '0;
            eng_mod    <= '0;
            rsp_id     <= 1'b0;
            rsp_data   <= '0;
            rr_dec     <= 1'b0;
        end else begin
            if (kg_launch) begin
                keys_valid <= 1'b0;
            end
            if (state == KG_PUB_WAIT && pub_finish) begin
                e_key <= public_key;
            end
            if (state == KG_PRIV_WAIT && priv_fin) begin
                d_key      <= private_key;
                n_key      <= n;
                keys_valid <= 1'b1;
            end
            if (do_grant) begin
                eng_msg <= pick_dec ? dec_data : enc_data;
                eng_exp <= pick_dec ? d_key : {8'h00, e_key};
                eng_mod <= n_key;
                rsp_id  <= pick_dec;
                rr_dec  <= !pick_dec;
            end
            if (state == OP_WAIT) begin
                if (eng_finished) begin
                    rsp_data <= eng_result;
                end else if (wait_expired) begin
                    rsp_data <= '0;
                end
            end
        end
    end

`ifdef RSA_SCHED_TIMEOUT_EN
    logic [15:0] wait_cnt;
    logic        in_wait;
    logic        timeout_fire;

    assign in_wait      = (state == KG_PUB_WAIT) || (state == KG_PRIV_WAIT) || (state == OP_WAIT);
    assign wait_expired = in_wait && (wait_cnt == 16'(TIMEOUT_CYCLES - 1));
    assign timeout_fire = wait_expired &&
                          !((state == KG_PUB_WAIT  && pub_finish) ||
                            (state == KG_PRIV_WAIT && priv_fin)   ||
                            (state == OP_WAIT      && eng_finished));

    // wait counter; any state change restarts it so each wait counts from zero
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state_next != state) begin
            wait_cnt <= '0;
        end else if (in_wait) begin
            wait_cnt <= wait_cnt + 16'd1;
        end
    end

    // sticky watchdog flag, cleared only by reset or a new keygen
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_timeout <= 1'b0;
        end else if (kg_launch) begin
            err_timeout <= 1'b0;
        end else if (timeout_fire) begin
            err_timeout <= 1'b1;
        end
    end
`else
    assign wait_expired = 1'b0;
    assign err_timeout  = 1'b0;
`endif

endmodule
